// File: rtl/cfg_serial_driver.sv
// Shifts one CFG_WIDTH-bit configuration word out MSB first, one bit per (SETUP_CYC + 1 + HOLD_CYC) cycles.
// A frame takes CFG_WIDTH*P + 1 cycles including the done pulse; cfg_ready stays low for the whole frame, and abort cancels it.
module cfg_serial_driver #(
   parameter int CFG_WIDTH = 24,
   parameter int SETUP_CYC = 1,
   parameter int HOLD_CYC  = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 cfg_valid,
   output logic                 cfg_ready,
   input  logic [CFG_WIDTH-1:0] cfg_data,
   input  logic                 abort,
   output logic                 ser_data,
   output logic                 ser_strobe,
   output logic                 busy,
   output logic                 done
);

   localparam int PMAX = (SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC;
   localparam int BW   = $clog2(CFG_WIDTH + 1);
   localparam int PW   = $clog2(PMAX + 1);

   localparam logic [BW-1:0] BITS_LD  = BW'(CFG_WIDTH);
   localparam logic [PW-1:0] SETUP_LD = PW'(SETUP_CYC - 1);
   localparam logic [PW-1:0] HOLD_LD  = PW'((HOLD_CYC > 0) ? HOLD_CYC - 1 : 0);

   typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, DONE} state_t;

   state_t               state;
   logic [CFG_WIDTH-1:0] shreg;
   logic [BW-1:0]        bits_left;
   logic [PW-1:0]        phase;
   logic                 bit_end;

   // End of a bit period: straight after the strobe when there is no hold phase.
   assign bit_end = ((state == STROBE) && (HOLD_CYC == 0)) ||
                    ((state == HOLD) && (phase == '0));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         shreg      <= '0;
         bits_left  <= '0;
         phase      <= '0;
         ser_data   <= 1'b0;
         ser_strobe <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         cfg_ready  <= 1'b1;
      end else if (state == IDLE) begin
         if (cfg_valid) begin
            shreg     <= cfg_data;
            bits_left <= BITS_LD;
            phase     <= SETUP_LD;
            ser_data  <= cfg_data[CFG_WIDTH-1];
            busy      <= 1'b1;
            cfg_ready <= 1'b0;
            state     <= SETUP;
         end
      end else if (abort) begin
         ser_data   <= 1'b0;
         ser_strobe <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         cfg_ready  <= 1'b1;
         state      <= IDLE;
      end else if (bit_end) begin
         ser_strobe <= 1'b0;
         bits_left  <= bits_left - 1'b1;
         if (bits_left == BW'(1)) begin
            ser_data <= 1'b0;
            done     <= 1'b1;
            state    <= DONE;
         end else begin
            shreg    <= shreg << 1;
            ser_data <= shreg[CFG_WIDTH-2];
            phase    <= SETUP_LD;
            state    <= SETUP;
         end
      end else begin
         case (state)
            SETUP: begin
               if (phase == '0) begin
                  ser_strobe <= 1'b1;
                  state      <= STROBE;
               end else begin
                  phase <= phase - 1'b1;
               end
            end
            STROBE: begin
               ser_strobe <= 1'b0;
               phase      <= HOLD_LD;
               state      <= HOLD;
            end
            HOLD: phase <= phase - 1'b1;
            DONE: begin
               done      <= 1'b0;
               busy      <= 1'b0;
               cfg_ready <= 1'b1;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cfg_serial_driver.sv
// Bench for cfg_serial_driver: instance 0 uses default timing, instance 1 uses SETUP_CYC=2/HOLD_CYC=0.
module tb_cfg_serial_driver;

   localparam int W = 24;
   localparam int P = 3;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         valid_i [2];
   logic         abort_i [2];
   logic [W-1:0] data_i  [2];
   logic         rdy_o   [2];
   logic         busy_o  [2];
   logic         done_o  [2];
   logic         stb_o   [2];
   logic         dat_o   [2];

   int n_chk = 0;
   int n_pass = 0;

   cfg_serial_driver #(.CFG_WIDTH(W), .SETUP_CYC(1), .HOLD_CYC(1)) dut_a (
      .clk(clk), .rst_n(rst_n), .cfg_valid(valid_i[0]), .cfg_ready(rdy_o[0]),
      .cfg_data(data_i[0]), .abort(abort_i[0]), .ser_data(dat_o[0]),
      .ser_strobe(stb_o[0]), .busy(busy_o[0]), .done(done_o[0]));

   cfg_serial_driver #(.CFG_WIDTH(W), .SETUP_CYC(2), .HOLD_CYC(0)) dut_b (
      .clk(clk), .rst_n(rst_n), .cfg_valid(valid_i[1]), .cfg_ready(rdy_o[1]),
      .cfg_data(data_i[1]), .abort(abort_i[1]), .ser_data(dat_o[1]),
      .ser_strobe(stb_o[1]), .busy(busy_o[1]), .done(done_o[1]));

   always #5 clk = ~clk;

   // Model: each instance has at most one frame in flight, described by its start cycle and word.
   int           cyc = 0;
   bit           act [2];
   int           st  [2];
   logic [W-1:0] wd  [2];
   bit           bz;

   function automatic int setup_of(input int m);
      return (m == 0) ? 1 : 2;
   endfunction

   function automatic logic [4:0] expect_vec(input int m, input int c);
      int k;
      logic [4:0] v;
      v = 5'b10000;
      if (act[m]) begin
         k = c - st[m];
         if (k >= 0 && k <= W*P) begin
            v[4] = 1'b0;
            v[3] = 1'b1;
            v[2] = (k == W*P);
            v[1] = (k < W*P) && ((k % P) == setup_of(m));
            v[0] = (k < W*P) ? wd[m][W-1-k/P] : 1'b0;
         end
      end
      return v;
   endfunction

   always @(posedge clk) begin
      for (int m = 0; m < 2; m++) begin
         bz = act[m] && ((cyc - st[m]) <= W*P);
         if (!bz) act[m] = 1'b0;
         if (!rst_n) begin
            act[m] = 1'b0;
         end else if (bz && abort_i[m]) begin
            act[m] = 1'b0;
         end else if (!bz && valid_i[m]) begin
            act[m] = 1'b1;
            st[m]  = cyc + 1;
            wd[m]  = data_i[m];
         end
      end
      cyc++;
   end

   always @(negedge rst_n) begin
      act[0] = 1'b0;
      act[1] = 1'b0;
   end

   // Receiver-side record of what actually came out of each instance.
   logic [63:0] rx [2];
   int ns [2], nd [2], fst [2], lst [2], dcy [2], rcy [2], gapbad [2], unstab [2];
   logic d1 [2], d2 [2];
   logic [4:0] got_v, exp_v;

   always @(negedge clk) begin
      for (int m = 0; m < 2; m++) begin
         got_v = {rdy_o[m], busy_o[m], done_o[m], stb_o[m], dat_o[m]};
         exp_v = expect_vec(m, cyc);
         n_chk++;
         if (got_v === exp_v) n_pass++;
         else $display("FAIL cycle_cmp dut%0d cyc %0d: got rdy/busy/done/stb/dat=%b want %b",
                       m, cyc, got_v, exp_v);
         if (stb_o[m]) begin
            rx[m] = {rx[m][62:0], dat_o[m]};
            if (lst[m] >= 0 && (cyc - lst[m]) != P) gapbad[m]++;
            if (m == 1 && (d1[m] !== dat_o[m] || d2[m] !== dat_o[m])) unstab[m]++;
            ns[m]++;
            if (fst[m] < 0) fst[m] = cyc;
            lst[m] = cyc;
         end
         if (done_o[m]) begin
            nd[m]++;
            dcy[m] = cyc;
         end else if (nd[m] > 0 && rdy_o[m] && rcy[m] < 0) begin
            rcy[m] = cyc;
         end
         d2[m] = d1[m];
         d1[m] = dat_o[m];
      end
   end

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h want %0h", nm, got, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic clr(input int m);
      rx[m] = '0; ns[m] = 0; nd[m] = 0; fst[m] = -1; lst[m] = -1;
      dcy[m] = -1; rcy[m] = -1; gapbad[m] = 0; unstab[m] = 0;
   endtask

   task automatic send(input int m, input logic [W-1:0] w, input logic ab, output int t0);
      step();
      valid_i[m] = 1'b1;
      data_i[m]  = w;
      abort_i[m] = ab;
      step();
      valid_i[m] = 1'b0;
      abort_i[m] = 1'b0;
      t0 = cyc;
   endtask

   task automatic wait_done(input int m, input int n, input int limit);
      int i;
      for (i = 0; i < limit; i++) begin
         step();
         if (nd[m] >= n) break;
      end
      if (i == limit) begin
         n_chk++;
         $display("FAIL wait_done dut%0d: got %0d done pulses want %0d within %0d cycles",
                  m, nd[m], n, limit);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   initial begin
      int t0;
      int s_before;
      for (int m = 0; m < 2; m++) begin
         valid_i[m] = 1'b0; abort_i[m] = 1'b0; data_i[m] = '0;
         clr(m);
      end
      repeat (3) step();
      chk("reset_outputs", {rdy_o[0], busy_o[0], done_o[0], stb_o[0], dat_o[0]}, 5'b10000);
      rst_n = 1'b1;
      step();

      // Default timing: strobes at 1,4,...,70, done at 72, ready at 73.
      clr(0);
      send(0, 24'h9FF001, 1'b0, t0);
      wait_done(0, 1, 200);
      repeat (4) step();
      chk("t1_word", rx[0][23:0], 24'h9FF001);
      chk("t1_strobes", ns[0], 24);
      chk("t1_first_strobe", fst[0] - t0, 1);
      chk("t1_last_strobe", lst[0] - t0, 70);
      chk("t1_gaps", gapbad[0], 0);
      chk("t1_done_cycle", dcy[0] - t0, 72);
      chk("t1_ready_cycle", rcy[0] - t0, 73);

      // SETUP_CYC=2, HOLD_CYC=0: strobes at 2,5,...,71, done at 72.
      clr(1);
      send(1, 24'hA5A5A5, 1'b0, t0);
      wait_done(1, 1, 200);
      repeat (4) step();
      chk("t2_word", rx[1][23:0], 24'hA5A5A5);
      chk("t2_first_strobe", fst[1] - t0, 2);
      chk("t2_last_strobe", lst[1] - t0, 71);
      chk("t2_setup_stable", unstab[1], 0);
      chk("t2_gaps", gapbad[1], 0);
      chk("t2_done_cycle", dcy[1] - t0, 72);

      // cfg_valid held through a frame: second word taken the cycle after done.
      clr(0);
      step();
      valid_i[0] = 1'b1;
      data_i[0]  = 24'hC3A50F;
      step();
      t0 = cyc;
      data_i[0] = 24'h123456;
      wait_done(0, 1, 200);
      step();
      valid_i[0] = 1'b0;
      wait_done(0, 2, 300);
      repeat (3) step();
      chk("t3_words", rx[0][47:0], 48'hC3A50F_123456);
      chk("t3_strobes", ns[0], 48);
      chk("t3_second_done", dcy[0] - t0, 146);

      // Abort during the 4th strobe (cycle 10).
      clr(0);
      send(0, 24'h5A3C96, 1'b0, t0);
      repeat (10) step();
      abort_i[0] = 1'b1;
      step();
      abort_i[0] = 1'b0;
      chk("t4_ready_after_abort", rdy_o[0], 1'b1);
      chk("t4_strobe_after_abort", stb_o[0], 1'b0);
      repeat (80) step();
      chk("t4_strobes", ns[0], 4);
      chk("t4_no_done", nd[0], 0);
      clr(0);
      send(0, 24'h3C5A69, 1'b0, t0);
      wait_done(0, 1, 200);
      repeat (3) step();
      chk("t4_next_word", rx[0][23:0], 24'h3C5A69);
      chk("t4_next_strobes", ns[0], 24);

      // Reset mid-frame at cycle 20.
      clr(0);
      send(0, 24'hE1D2C3, 1'b0, t0);
      repeat (20) step();
      chk("t5_strobes_before_reset", ns[0], 7);
      s_before = ns[0];
      rst_n = 1'b0;
      #1;
      chk("t5_async_reset_out", {rdy_o[0], busy_o[0], done_o[0], stb_o[0], dat_o[0]}, 5'b10000);
      repeat (3) step();
      chk("t5_no_strobe_in_reset", ns[0], s_before);
      rst_n = 1'b1;
      step();
      clr(0);
      send(0, 24'h0F1E2D, 1'b0, t0);
      wait_done(0, 1, 200);
      repeat (3) step();
      chk("t5_word_after_reset", rx[0][23:0], 24'h0F1E2D);
      chk("t5_strobes_after_reset", ns[0], 24);

      // abort together with cfg_valid in IDLE: accept proceeds normally.
      clr(0);
      send(0, 24'h96C3A5, 1'b1, t0);
      wait_done(0, 1, 200);
      repeat (3) step();
      chk("t6_word", rx[0][23:0], 24'h96C3A5);
      chk("t6_strobes", ns[0], 24);
      chk("t6_done_count", nd[0], 1);
      chk("t6_done_cycle", dcy[0] - t0, 72);

      repeat (2) step();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
